mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multi-cycle MIPS core between two requesters: port 0 (CPU datapath: instruction fetch and load/store) and port 1 (program loader/debug master).
- Sequences each access over a fixed multi-cycle memory latency and returns a one-cycle acknowledge.
- Sits between the core/loader and the memory model. The CPU controller holds its current state until p0_ack.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 2, cycles the memory strobes are held before read data is sampled; legal range 1..15

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- p0_req  input  1  port 0 access request, level
- p0_we  input  1  port 0 write enable (1 = write, 0 = read)
- p0_adr  input  ADDR_W  port 0 address
- p0_wdata  input  DATA_W  port 0 write data
- p0_ack  output  1  port 0 access complete, one-cycle pulse
- p1_req, p1_we, p1_adr, p1_wdata, p1_ack: same as port 0, for port 1
- rdata  output  DATA_W  read data; valid only in the cycle px_ack is high
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_adr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data
- busy  output  1  high in ACCESS and DONE
- gnt_id  output  1  port currently being served; holds its last value when idle

Behaviour:
- Reset values: state IDLE; all strobes, acks and busy at 0; mem_adr, mem_wdata and rdata at 0; gnt_id 0; last_gnt 1, so port 0 wins the first contention. Reset is asynchronous and takes effect immediately.
- IDLE state:
  - No req: stay in IDLE.
  - One req: grant that port.
  - Both req: grant the port that is not last_gnt (round-robin).
  - On grant: latch we, adr and wdata into internal regs; set gnt_id; cnt = MEM_LATENCY-1; go to ACCESS.
- ACCESS state:
  - mem_adr and mem_wdata are driven from the latched regs. mem_read = !we, mem_write = we; both held steady for exactly MEM_LATENCY cycles.
  - Each cycle: if cnt==0, rdata <= mem_rdata for reads (rdata unchanged for writes) and go to DONE; else cnt--.
- DONE state:
  - Strobes low; ack pulses for the granted port only.
  - last_gnt <= gnt_id; go to IDLE.
- Latency: request sampled in IDLE, ack exactly MEM_LATENCY+1 cycles later. Back-to-back period is MEM_LATENCY+2 cycles per access.
- Requester inputs are don't-care after the grant, because the latched copies are used. Dropping req mid-access does not abort: the access completes and ack still pulses.
- A req still high in the cycle after ack is treated as a new request.
- A port is never starved: with both ports requesting continuously, grants strictly alternate.
- Reset mid-ACCESS: strobes drop at once, no ack is issued, and the pending access is lost.
- mem_read and mem_write are never high together. No ack is issued outside DONE.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding localparams S_IDLE=2'd0, S_ACCESS=2'd1, S_DONE=2'd2
  - PORT_CPU=1'b0, PORT_LDR=1'b1
- One sub-module, arb_rr2: combinational two-way round-robin pick. Inputs req[1:0] and last_gnt; outputs gnt_valid and gnt_id.
- FSM, counter and latches live in the top module.

Test Plan:
- Port 0 read only, MEM_LATENCY=2, p0_adr=0x10, mem model returns 0xDEADBEEF → mem_read high 2 cycles with mem_adr=0x10; p0_ack high 3 cycles after the request cycle; rdata=0xDEADBEEF; p1_ack stays 0.
- Port 1 write, adr=0x20, wdata=0x12345678 → mem_write high 2 cycles, mem_wdata=0x12345678, mem_read 0 throughout; p1_ack single pulse.
- Both ports request in the same cycle out of reset → port 0 served first, then port 1. Holding both reqs high gives strictly alternating acks 0,1,0,1 with a period of 4 cycles each.
- p0 changes adr from 0x10 to 0x99 one cycle after the grant → mem_adr stays 0x10 for the whole access.
- rst asserted in the second ACCESS cycle → strobes and busy drop in the same cycle, no ack. After release, a new p0 read completes normally.
- MEM_LATENCY=1 build, single read → strobe high 1 cycle; ack 2 cycles after the request; rdata correct.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - combinational two-way round-robin pick
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_CPU;
    // On contention the port that did not win last time goes first.
    if (&req)
      gnt_id = ~last_gnt;
    else if (req[1])
      gnt_id = PORT_LDR;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one multi-cycle memory port between CPU and loader
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_adr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_adr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_id
);
  import mem_arb_pkg::*;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_gnt_id;
  logic              r_last_gnt;
  logic              w_gnt_valid;
  logic              w_gnt_id;

  arb_rr2 u_arb (
    .req       ({p1_req, p0_req}),
    .last_gnt  (r_last_gnt),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    busy      = 1'b0;
    p0_ack    = 1'b0;
    p1_ack    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_valid)
          w_next = S_ACCESS;
      end
      S_ACCESS: begin
        busy      = 1'b1;
        mem_read  = ~r_we;
        mem_write = r_we;
        if (r_cnt == 4'd0)
          w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        p0_ack = (r_gnt_id == PORT_CPU);
        p1_ack = (r_gnt_id == PORT_LDR);
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Requester inputs are captured at grant so they may change during the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_adr      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_gnt_id   <= PORT_CPU;
      r_last_gnt <= PORT_LDR;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_valid) begin
            r_gnt_id <= w_gnt_id;
            r_we     <= (w_gnt_id == PORT_LDR) ? p1_we    : p0_we;
            r_adr    <= (w_gnt_id == PORT_LDR) ? p1_adr   : p0_adr;
            r_wdata  <= (w_gnt_id == PORT_LDR) ? p1_wdata : p0_wdata;
            r_cnt    <= CNT_INIT;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (!r_we)
              r_rdata <= mem_rdata;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: r_last_gnt <= r_gnt_id;
        default: ;
      endcase
    end
  end

  assign mem_adr   = r_adr;
  assign mem_wdata = r_wdata;
  assign rdata     = r_rdata;
  assign gnt_id    = r_gnt_id;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [31:0] p0_adr = '0, p0_wdata = '0;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0] p1_adr = '0, p1_wdata = '0;
  logic        p0_ack, p1_ack, mem_read, mem_write, busy, gnt_id;
  logic [31:0] rdata, mem_adr, mem_wdata, mem_rdata;

  logic        q_req = 1'b0;
  logic [31:0] q_adr = '0;
  logic        q_ack, q_p1_ack, q_mem_read, q_mem_write, q_busy, q_gnt;
  logic [31:0] q_rdata, q_mem_adr, q_mem_wdata, q_mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'd7);
  endfunction

  assign mem_rdata   = mem_f(mem_adr);
  assign q_mem_rdata = mem_f(q_mem_adr);

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) u_dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_adr(p0_adr), .p0_wdata(p0_wdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_adr(p1_adr), .p1_wdata(p1_wdata), .p1_ack(p1_ack),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .p0_req(q_req), .p0_we(1'b0), .p0_adr(q_adr), .p0_wdata(32'd0), .p0_ack(q_ack),
    .p1_req(1'b0), .p1_we(1'b0), .p1_adr(32'd0), .p1_wdata(32'd0), .p1_ack(q_p1_ack),
    .rdata(q_rdata), .mem_read(q_mem_read), .mem_write(q_mem_write), .mem_adr(q_mem_adr),
    .mem_wdata(q_mem_wdata), .mem_rdata(q_mem_rdata), .busy(q_busy), .gnt_id(q_gnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: each grant occupies a timeline window of
  // L strobe cycles followed by one ack cycle; next grant is possible one cycle later.
  int          cyc = 0;
  int          m_start = 0;
  bit          m_active = 0, m_port = 0, m_we = 0, m_last = 1, m_gnt = 0;
  logic [31:0] m_adr = '0, m_wdata = '0;

  always @(posedge clk or posedge rst) begin
    int c;
    bit pt;
    if (rst) begin
      m_active <= 0;
      m_last   <= 1;
      m_gnt    <= 0;
    end else begin
      c = cyc + 1;
      cyc <= c;
      if (m_active) begin
        if (c == m_start + L + 1) begin
          m_active <= 0;
          m_last   <= m_port;
        end
      end else if (p0_req || p1_req) begin
        pt = (p0_req && p1_req) ? !m_last : p1_req;
        m_active <= 1;
        m_start  <= c;
        m_port   <= pt;
        m_gnt    <= pt;
        m_we     <= pt ? p1_we    : p0_we;
        m_adr    <= pt ? p1_adr   : p0_adr;
        m_wdata  <= pt ? p1_wdata : p0_wdata;
      end
    end
  end

  always @(negedge clk) begin
    logic in_acc, in_done;
    if (rst) begin
      chk("rst_ctrl", {58'd0, mem_read, mem_write, busy, p0_ack, p1_ack, gnt_id}, 64'd0);
      chk("rst_adr_rdata", {mem_adr, rdata}, 64'd0);
      chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
    end else begin
      in_acc  = m_active && (cyc >= m_start) && (cyc < m_start + L);
      in_done = m_active && (cyc == m_start + L);
      chk("ctrl", {58'd0, mem_read, mem_write, busy, p0_ack, p1_ack, gnt_id},
          {58'd0, in_acc && !m_we, in_acc && m_we, in_acc || in_done,
           in_done && !m_port, in_done && m_port, m_gnt});
      if (in_acc) chk("mem_adr", {32'd0, mem_adr}, {32'd0, m_adr});
      if (in_acc && m_we) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, m_wdata});
      if (in_done && !m_we) chk("rdata", {32'd0, rdata}, {32'd0, mem_f(m_adr)});
    end
  end

  int ack_port[$];
  int ack_cyc[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (p0_ack) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
      if (p1_ack) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
    end
  end

  task automatic run_access(input string nm, input bit port, input bit we,
                            input logic [31:0] adr, input logic [31:0] wdata,
                            input bit chg, input int exp_lat, input logic [31:0] exp_rd);
    int lat = -1, nr = 0, nw = 0, bad = 0, other = 0;
    @(posedge clk); #2;
    if (!port) begin p0_req = 1; p0_we = we; p0_adr = adr; p0_wdata = wdata; end
    else       begin p1_req = 1; p1_we = we; p1_adr = adr; p1_wdata = wdata; end
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (mem_read) nr++;
      if (mem_write) nw++;
      if ((mem_read || mem_write) && (mem_adr !== adr || (we && mem_wdata !== wdata))) bad++;
      if (port ? p0_ack : p1_ack) other++;
      if (chg && j == 1) begin
        if (!port) begin p0_adr = 32'h99; p0_req = 0; end
        else       begin p1_adr = 32'h99; p1_req = 0; end
      end
      if (port ? p1_ack : p0_ack) begin
        lat = j;
        if (!we) chk({nm, "_rdata"}, {32'd0, rdata}, {32'd0, exp_rd});
        break;
      end
    end
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_rd_strobes"}, 64'(nr), we ? 64'd0 : 64'(L));
    chk({nm, "_wr_strobes"}, 64'(nw), we ? 64'(L) : 64'd0);
    chk({nm, "_bus_hold"}, 64'(bad), 64'd0);
    chk({nm, "_other_ack"}, 64'(other), 64'd0);
    @(posedge clk); #2;
    p0_req = 0;
    p1_req = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1;
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
  endtask

  initial begin
    int t0, n_ack, lat1, nr1;

    repeat (3) @(posedge clk);
    #2;
    rst = 0;
    @(negedge clk);
    chk("reset_state", {60'd0, busy, gnt_id, p0_ack, p1_ack}, 64'd0);

    run_access("p0_rd", 0, 0, 32'h10, 32'h0, 0, 3, 32'hDEADBEEF);
    run_access("p1_wr", 1, 1, 32'h20, 32'h12345678, 0, 3, 32'h0);
    run_access("p1_rd", 1, 0, 32'h40, 32'h0, 0, 3, 32'h5A5A0047);
    run_access("p0_wr", 0, 1, 32'h60, 32'hA5A5A5A5, 0, 3, 32'h0);

    do_reset();
    ack_port.delete();
    ack_cyc.delete();
    @(posedge clk); #2;
    p0_we = 0; p0_adr = 32'h30; p1_we = 0; p1_adr = 32'h40;
    p0_req = 1; p1_req = 1;
    t0 = cyc;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk); #1;
      if (ack_port.size() >= 4) break;
    end
    @(posedge clk); #2;
    p0_req = 0; p1_req = 0;
    chk("rr_ack_count", 64'(ack_port.size()), 64'd4);
    if (ack_port.size() >= 4) begin
      chk("rr_first_lat", 64'(ack_cyc[0] - t0), 64'd3);
      for (int i = 0; i < 4; i++) chk("rr_order", 64'(ack_port[i]), 64'(i % 2));
      for (int i = 1; i < 4; i++) chk("rr_period", 64'(ack_cyc[i] - ack_cyc[i-1]), 64'd4);
    end

    run_access("p0_adr_chg", 0, 0, 32'h10, 32'h0, 1, 3, 32'hDEADBEEF);

    @(posedge clk); #2;
    p0_req = 1; p0_we = 0; p0_adr = 32'h50;
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_rst_strobe", {62'd0, mem_read, busy}, 64'd3);
    rst = 1;
    p0_req = 0;
    #1;
    chk("mid_rst_strobe", {62'd0, mem_read, busy}, 64'd0);
    @(posedge clk); #2;
    rst = 0;
    n_ack = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) n_ack++;
    end
    chk("post_rst_no_ack", 64'(n_ack), 64'd0);
    run_access("p0_after_rst", 0, 0, 32'h10, 32'h0, 0, 3, 32'hDEADBEEF);

    @(posedge clk); #2;
    q_req = 1; q_adr = 32'h10;
    lat1 = -1; nr1 = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (q_mem_read) nr1++;
      if (q_ack) begin
        lat1 = j;
        chk("lat1_rdata", {32'd0, q_rdata}, 64'hDEADBEEF);
        break;
      end
    end
    chk("lat1_latency", 64'(lat1), 64'd2);
    chk("lat1_strobes", 64'(nr1), 64'd1);
    @(posedge clk); #2;
    q_req = 0;

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
